// File: rtl/maquina_pkg.sv
// Shared types for the coffee controller: drink/size codes, FSM states,
// queued-order record, and the price and dispenser-flag decoders.
package maquina_pkg;

  typedef enum logic [2:0] {
    T_ESPRESSO  = 3'd0,
    T_AMERICANO = 3'd1,
    T_CAPPUCCINO= 3'd2,
    T_LATTE     = 3'd3,
    T_MOCHA     = 3'd4
  } tipo_e;

  typedef enum logic [1:0] {
    S_SMALL  = 2'd0,
    S_MEDIUM = 2'd1,
    S_LARGE  = 2'd2
  } tamano_e;

  typedef enum logic [1:0] {IDLE, COBRO, PREPARA, ENTREGA} estado_e;

  typedef struct packed {
    logic [2:0] tipo;
    logic [1:0] tamano;
    logic [2:0] azucar;
  } pedido_t;

  typedef struct packed {
    logic concentracion;
    logic leche;
    logic espuma;
  } flags_t;

  function automatic logic pedido_ok(input logic [2:0] tipo, input logic [1:0] tamano);
    return (tipo <= T_MOCHA) && (tamano <= S_LARGE);
  endfunction

  function automatic logic [2:0] precio_base(input logic [2:0] tipo);
    case (tipo)
      T_ESPRESSO:   return 3'd2;
      T_AMERICANO:  return 3'd3;
      T_CAPPUCCINO: return 3'd4;
      T_LATTE:      return 3'd4;
      T_MOCHA:      return 3'd5;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic flags_t decode_flags(input logic [2:0] tipo);
    flags_t f;
    f.concentracion = (tipo == T_ESPRESSO);
    f.leche         = (tipo == T_CAPPUCCINO) || (tipo == T_LATTE) || (tipo == T_MOCHA);
    f.espuma        = (tipo == T_CAPPUCCINO) || (tipo == T_MOCHA);
    return f;
  endfunction

endpackage

// File: rtl/maquina_cafe_cola_if.sv
// Front-panel / coin / dispenser bundle for maquina_cafe_cola.
// slave = controller side, master = panel/test side.
interface maquina_cafe_cola_if #(
  parameter int PRECIO_W = 6,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                pedido_valid;
  logic                pedido_ready;
  logic [2:0]          tipo_cafe_in;
  logic [1:0]          tamano_in;
  logic [2:0]          nivel_azucar_in;
  logic                moneda_valid;
  logic [PRECIO_W-1:0] moneda_valor;
  logic                cancelar;
  logic                pedido_error;
  logic [CNT_W-1:0]    pedidos_pend;
  logic [PRECIO_W-1:0] precio;
  logic [PRECIO_W-1:0] credito;
  logic [PRECIO_W-1:0] cambio;
  logic                cambio_valid;
  logic                concentracion;
  logic                leche;
  logic                espuma;
  logic [2:0]          nivel_azucar_out;
  logic                sirviendo;
  logic                listo;

  modport slave (
    input  pedido_valid, tipo_cafe_in, tamano_in, nivel_azucar_in,
           moneda_valid, moneda_valor, cancelar,
    output pedido_ready, pedido_error, pedidos_pend, precio, credito,
           cambio, cambio_valid, concentracion, leche, espuma,
           nivel_azucar_out, sirviendo, listo
  );

  modport master (
    output pedido_valid, tipo_cafe_in, tamano_in, nivel_azucar_in,
           moneda_valid, moneda_valor, cancelar,
    input  pedido_ready, pedido_error, pedidos_pend, precio, credito,
           cambio, cambio_valid, concentracion, leche, espuma,
           nivel_azucar_out, sirviendo, listo
  );
endinterface

// File: rtl/maquina_cafe_cola_pedido_fifo.sv
// Order queue: DEPTH-entry circular buffer of {tipo, tamano, azucar}.
module pedido_fifo
  import maquina_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  pedido_t                    i_din,
  input  logic                       i_pop,
  output pedido_t                    o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  pedido_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok, w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk)
    if (w_push_ok) r_mem[r_wptr] <= i_din;

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/maquina_cafe_cola.sv
// Queued coffee controller: price, coin payment with change/refund, timed brew.
// Optional MAQUINA_TIMEOUT_EN: refund and drop an order after TIMEOUT_CYCLES coinless cycles.
module maquina_cafe_cola
  import maquina_pkg::*;
#(
  parameter int PRECIO_W       = 6,
  parameter int DEPTH          = 4,
  parameter int BREW_BASE      = 8,
  parameter int AZUCAR_MAX     = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  maquina_cafe_cola_if.slave bus
);
  localparam int BREW_W = $clog2(BREW_BASE*4+1);

  estado_e             r_state, w_nxt_state;
  pedido_t             r_cur, w_dout;
  logic [PRECIO_W-1:0] r_credito, w_nxt_credito;
  logic [PRECIO_W-1:0] r_cambio, w_nxt_cambio;
  logic                r_cvld, w_nxt_cvld;
  logic [BREW_W-1:0]   r_brew, w_nxt_brew;
  logic                r_err;
  logic                w_full, w_empty, w_push, w_pop, w_ok, w_cancel, w_timeout;
  logic [PRECIO_W-1:0] w_precio, w_coin, w_sum;
  logic [PRECIO_W:0]   w_sum_ext;
  flags_t              w_flags;

  assign w_ok   = pedido_ok(bus.tipo_cafe_in, bus.tamano_in);
  assign w_push = bus.pedido_valid && !w_full && w_ok;
  assign w_pop  = (r_state == IDLE) && !w_empty;

  pedido_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ('{tipo: bus.tipo_cafe_in, tamano: bus.tamano_in, azucar: bus.nivel_azucar_in}),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (bus.pedidos_pend)
  );

  assign w_precio  = PRECIO_W'(precio_base(r_cur.tipo)) + PRECIO_W'(r_cur.tamano);
  assign w_coin    = bus.moneda_valid ? bus.moneda_valor : '0;
  assign w_sum_ext = {1'b0, r_credito} + {1'b0, w_coin};
  assign w_sum     = w_sum_ext[PRECIO_W] ? '1 : w_sum_ext[PRECIO_W-1:0];
  assign w_cancel  = bus.cancelar || w_timeout;

`ifdef MAQUINA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);
  logic [TMO_W-1:0] r_tmo;

  assign w_timeout = (r_state == COBRO) && !bus.moneda_valid &&
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      r_tmo <= '0;
    else if (r_state != COBRO || bus.moneda_valid)   r_tmo <= '0;
    else                                             r_tmo <= r_tmo + TMO_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_credito = r_credito;
    w_nxt_cambio  = '0;
    w_nxt_cvld    = 1'b0;
    w_nxt_brew    = r_brew;
    case (r_state)
      IDLE: if (!w_empty) w_nxt_state = COBRO;
      COBRO: begin
        // a cancel in the same cycle as the completing coin refunds everything
        if (w_cancel) begin
          w_nxt_cambio  = w_sum;
          w_nxt_cvld    = 1'b1;
          w_nxt_credito = '0;
          w_nxt_state   = IDLE;
        end else if (w_sum >= w_precio) begin
          w_nxt_cambio  = w_sum - w_precio;
          w_nxt_cvld    = 1'b1;
          w_nxt_credito = '0;
          w_nxt_brew    = BREW_W'(BREW_BASE * (int'(r_cur.tamano) + 1) - 1);
          w_nxt_state   = PREPARA;
        end else begin
          w_nxt_credito = w_sum;
        end
      end
      PREPARA: begin
        if (r_brew == '0) w_nxt_state = ENTREGA;
        else              w_nxt_brew  = r_brew - BREW_W'(1);
      end
      ENTREGA: w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cur     <= '0;
      r_credito <= '0;
      r_cambio  <= '0;
      r_cvld    <= 1'b0;
      r_brew    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_credito <= w_nxt_credito;
      r_cambio  <= w_nxt_cambio;
      r_cvld    <= w_nxt_cvld;
      r_brew    <= w_nxt_brew;
      r_err     <= bus.pedido_valid && !w_ok;
      if (w_pop) r_cur <= w_dout;
    end
  end

  assign w_flags              = decode_flags(r_cur.tipo);
  assign bus.pedido_ready     = !w_full;
  assign bus.pedido_error     = r_err;
  assign bus.precio           = (r_state != IDLE) ? w_precio : '0;
  assign bus.credito          = r_credito;
  assign bus.cambio           = r_cambio;
  assign bus.cambio_valid     = r_cvld;
  assign bus.sirviendo        = (r_state == PREPARA);
  assign bus.listo            = (r_state == ENTREGA);
  assign bus.concentracion    = bus.sirviendo && w_flags.concentracion;
  assign bus.leche            = bus.sirviendo && w_flags.leche;
  assign bus.espuma           = bus.sirviendo && w_flags.espuma;
  assign bus.nivel_azucar_out = !bus.sirviendo ? 3'd0 :
                                (r_cur.azucar > 3'(AZUCAR_MAX)) ? 3'(AZUCAR_MAX) : r_cur.azucar;
endmodule

// File: tb/tb_maquina_cafe_cola.sv
// Scoreboard bench for maquina_cafe_cola: stimulus queues expected change/cup
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_maquina_cafe_cola;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maquina_cafe_cola_if #(.PRECIO_W(6), .DEPTH(4)) bus();

  maquina_cafe_cola dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit is_listo;
    int val;
    int ciclos;
    bit c, l, e;
    int az;
    int pr;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_cambio(input int v);
    exp_t x;
    x = '{is_listo: 1'b0, val: v, ciclos: 0, c: 1'b0, l: 1'b0, e: 1'b0, az: 0, pr: 0};
    sb.push_back(x);
  endtask

  task automatic exp_listo(input int cyc, input bit c, input bit l, input bit e, input int az, input int pr);
    exp_t x;
    x = '{is_listo: 1'b1, val: 0, ciclos: cyc, c: c, l: l, e: e, az: az, pr: pr};
    sb.push_back(x);
  endtask

  // monitor: counts brew cycles and snapshots dispenser outputs while serving
  initial begin
    int srv_cnt;
    bit s_c, s_l, s_e;
    int s_az, s_pr;
    exp_t x;
    srv_cnt = 0; s_c = 0; s_l = 0; s_e = 0; s_az = 0; s_pr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) srv_cnt = 0;
      else begin
        if (bus.sirviendo) begin
          srv_cnt++;
          s_c = bus.concentracion; s_l = bus.leche; s_e = bus.espuma;
          s_az = int'(bus.nivel_azucar_out); s_pr = int'(bus.precio);
        end
        if (bus.cambio_valid) begin
          if (sb.size() == 0 || sb[0].is_listo) chk("seq_cambio_unexpected", 1, 0);
          else begin
            x = sb.pop_front();
            chk("cambio", int'(bus.cambio), x.val);
          end
        end
        if (bus.listo) begin
          if (sb.size() == 0 || !sb[0].is_listo) chk("seq_listo_unexpected", 1, 0);
          else begin
            x = sb.pop_front();
            chk("brew_cycles", srv_cnt, x.ciclos);
            chk("concentracion", int'(s_c), int'(x.c));
            chk("leche", int'(s_l), int'(x.l));
            chk("espuma", int'(s_e), int'(x.e));
            chk("azucar_out", s_az, x.az);
            chk("precio_srv", s_pr, x.pr);
          end
          srv_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int t, input int tm, input int az);
    int n;
    n = 0;
    bus.pedido_valid    = 1'b1;
    bus.tipo_cafe_in    = 3'(t);
    bus.tamano_in       = 2'(tm);
    bus.nivel_azucar_in = 3'(az);
    while (!bus.pedido_ready && n < 300) begin tick(); n++; end
    if (n >= 300) chk("push_wait_bound", 0, 1);
    tick();
    bus.pedido_valid = 1'b0;
  endtask

  task automatic coin(input int v, input bit canc);
    bus.moneda_valid = 1'b1;
    bus.moneda_valor = 6'(v);
    bus.cancelar     = canc;
    tick();
    bus.moneda_valid = 1'b0;
    bus.moneda_valor = '0;
    bus.cancelar     = 1'b0;
  endtask

  task automatic wait_cobro();
    int n;
    n = 0;
    while (!(bus.precio != 0 && !bus.sirviendo && !bus.listo) && n < 300) begin tick(); n++; end
    if (n >= 300) chk("cobro_wait_bound", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin tick(); n++; end
    chk("scoreboard_drained", sb.size(), 0);
    tick();
  endtask

  // queue-fill orders: tipo, tamano, azucar, price, brew cycles, c, l, e, azucar_out
  int q_t  [5] = '{1, 2, 3, 4, 0};
  int q_tm [5] = '{1, 2, 0, 2, 1};
  int q_az [5] = '{1, 3, 6, 4, 7};
  int q_pr [5] = '{4, 6, 4, 7, 3};
  int q_cy [5] = '{16, 24, 8, 24, 16};
  bit q_c  [5] = '{0, 0, 0, 0, 1};
  bit q_l  [5] = '{0, 1, 1, 1, 0};
  bit q_e  [5] = '{0, 1, 0, 1, 0};
  int q_ao [5] = '{1, 3, 5, 4, 5};

  initial begin
    bus.pedido_valid = 0; bus.tipo_cafe_in = 0; bus.tamano_in = 0; bus.nivel_azucar_in = 0;
    bus.moneda_valid = 0; bus.moneda_valor = 0; bus.cancelar = 0;
    repeat (3) tick();
    chk("rst_ready", int'(bus.pedido_ready), 1);
    chk("rst_pend", int'(bus.pedidos_pend), 0);
    chk("rst_precio", int'(bus.precio), 0);
    chk("rst_credito", int'(bus.credito), 0);
    chk("rst_sirviendo", int'(bus.sirviendo), 0);
    chk("rst_listo", int'(bus.listo), 0);
    rst_n = 1'b1;
    tick();

    // coin while idle is not credited
    coin(3, 0);
    chk("idle_coin_ignored", int'(bus.credito), 0);

    // latte large, sugar 7 -> price 6, change 4, 24 cycles, sugar capped at 5
    push(3, 2, 7);
    chk("latte_pend_after_push", int'(bus.pedidos_pend), 1);
    wait_cobro();
    chk("latte_precio", int'(bus.precio), 6);
    exp_cambio(4);
    exp_listo(24, 0, 1, 0, 5, 6);
    coin(5, 0);
    chk("latte_credito_partial", int'(bus.credito), 5);
    coin(5, 0);
    chk("latte_credito_cleared", int'(bus.credito), 0);
    wait_drain();

    // espresso small, exact coin
    push(0, 0, 0);
    wait_cobro();
    chk("espresso_precio", int'(bus.precio), 2);
    exp_cambio(0);
    exp_listo(8, 1, 0, 0, 0, 2);
    coin(2, 0);
    wait_drain();

    // mocha medium cancelled with same-cycle coin; queued americano follows
    push(4, 1, 2);
    push(1, 0, 1);
    wait_cobro();
    chk("mocha_precio", int'(bus.precio), 6);
    coin(3, 0);
    chk("mocha_credito", int'(bus.credito), 3);
    exp_cambio(5);
    coin(2, 1);
    chk("cancel_precio_idle", int'(bus.precio), 0);
    chk("cancel_credito", int'(bus.credito), 0);
    chk("cancel_pend", int'(bus.pedidos_pend), 1);
    wait_cobro();
    chk("americano_precio", int'(bus.precio), 3);
    exp_cambio(1);
    exp_listo(8, 0, 0, 0, 1, 3);
    coin(4, 0);
    wait_drain();

    // fill the queue while order 0 is waiting for payment
    push(0, 0, 0);
    wait_cobro();
    for (int i = 0; i < 4; i++) push(q_t[i], q_tm[i], q_az[i]);
    chk("full_pend", int'(bus.pedidos_pend), 4);
    chk("full_ready", int'(bus.pedido_ready), 0);
    fork
      push(q_t[4], q_tm[4], q_az[4]);
      begin
        repeat (3) tick();
        chk("held_pend", int'(bus.pedidos_pend), 4);
        chk("held_ready", int'(bus.pedido_ready), 0);
        exp_cambio(0);
        exp_listo(8, 1, 0, 0, 0, 2);
        coin(2, 0);
      end
    join
    for (int i = 0; i < 5; i++) begin
      wait_cobro();
      chk("fifo_order_precio", int'(bus.precio), q_pr[i]);
      exp_cambio(i);
      exp_listo(q_cy[i], q_c[i], q_l[i], q_e[i], q_ao[i], q_pr[i]);
      coin(q_pr[i] + i, 0);
    end
    wait_drain();
    chk("fifo_pend_empty", int'(bus.pedidos_pend), 0);

    // invalid orders
    push(6, 0, 0);
    chk("bad_tipo_error", int'(bus.pedido_error), 1);
    chk("bad_tipo_pend", int'(bus.pedidos_pend), 0);
    tick();
    chk("error_is_pulse", int'(bus.pedido_error), 0);
    push(2, 3, 0);
    chk("bad_tamano_error", int'(bus.pedido_error), 1);
    chk("bad_tamano_pend", int'(bus.pedidos_pend), 0);
    repeat (3) tick();
    chk("bad_no_cobro", int'(bus.precio), 0);

    // reset in the middle of a brew
    push(3, 2, 7);
    wait_cobro();
    push(1, 0, 0);
    push(0, 0, 0);
    exp_cambio(4);
    coin(10, 0);
    repeat (5) tick();
    chk("pre_rst_sirviendo", int'(bus.sirviendo), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sirviendo", int'(bus.sirviendo), 0);
    chk("rst_mid_leche", int'(bus.leche), 0);
    chk("rst_mid_azucar", int'(bus.nivel_azucar_out), 0);
    chk("rst_mid_pend", int'(bus.pedidos_pend), 0);
    chk("rst_mid_precio", int'(bus.precio), 0);
    chk("rst_mid_cambio_valid", int'(bus.cambio_valid), 0);
    chk("rst_mid_sb_empty", sb.size(), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_precio", int'(bus.precio), 0);
    chk("post_rst_pend", int'(bus.pedidos_pend), 0);

`ifdef MAQUINA_TIMEOUT_EN
    push(4, 0, 0);
    wait_cobro();
    coin(3, 0);
    repeat (60) tick();
    chk("tmo_credito_held", int'(bus.credito), 3);
    exp_cambio(3);
    wait_drain();
    chk("tmo_precio_idle", int'(bus.precio), 0);
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
